// File: rtl/mmcm_ps_ctrl.sv
// MMCM fine phase-shift sequencer: issues PSEN pulses one at a time, tracks the net phase position
// and flags lock loss. Define MMCM_PS_TIMEOUT_EN to add a watchdog on missing PSDONE.
module mmcm_ps_ctrl #(
    parameter int POS_W          = 16,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             free_run_clk,
    input  logic             free_run_rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [POS_W-1:0] cmd_steps,
    input  logic             pos_clr,
    input  logic             err_clr,
    input  logic             locked,
    output logic             ps_en,
    output logic             ps_incdec,
    input  logic             ps_done,
    output logic             busy,
    output logic             done,
    output logic [1:0]       err,
    output logic [POS_W-1:0] phase_pos,
    output logic [POS_W-1:0] steps_left
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STEP,
        S_WAIT_DONE,
        S_GAP,
        S_FINISH,
        S_ERROR
    } state_t;

    localparam logic [POS_W-1:0] ONE      = POS_W'(1);
    localparam logic [7:0]       GAP_LAST = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

    state_t           state_reg, state_next;
    logic             dir_reg, dir_next;
    logic [POS_W-1:0] left_reg, left_next;
    logic [POS_W-1:0] pos_reg, pos_next;
    logic [7:0]       gap_cnt_reg, gap_cnt_next;
    logic             lock_err_reg, lock_err_next;
    logic             accept;

`ifdef MMCM_PS_TIMEOUT_EN
    localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);
    logic [15:0] to_cnt_reg, to_cnt_next;
    logic        timeout_err_reg, timeout_err_next;
    assign err = {timeout_err_reg, lock_err_reg};
`else
    assign err = {1'b0, lock_err_reg};
`endif

    // Ready is held low while reset is asserted so every output reads zero during reset.
    assign cmd_ready  = (state_reg == S_IDLE) && locked && (err == 2'b00) && !free_run_rst;
    assign accept     = cmd_valid && cmd_ready;
    assign ps_en      = (state_reg == S_STEP) && locked;
    assign ps_incdec  = ps_en && dir_reg;
    assign busy       = (state_reg != S_IDLE);
    assign phase_pos  = pos_reg;
    assign steps_left = left_reg;

    always_comb begin
        state_next    = state_reg;
        dir_next      = dir_reg;
        left_next     = left_reg;
        pos_next      = pos_reg;
        gap_cnt_next  = gap_cnt_reg;
        lock_err_next = lock_err_reg;
        done          = 1'b0;
`ifdef MMCM_PS_TIMEOUT_EN
        to_cnt_next      = to_cnt_reg;
        timeout_err_next = timeout_err_reg;
`endif
        case (state_reg)
            S_IDLE: begin
                if (pos_clr) begin
                    pos_next = '0;
                end
                if (accept) begin
                    dir_next   = cmd_dir;
                    left_next  = cmd_steps;
                    state_next = (cmd_steps == '0) ? S_FINISH : S_STEP;
                end
            end
            S_STEP: begin
                if (!locked) begin
                    lock_err_next = 1'b1;
                    done          = 1'b1;
                    state_next    = S_ERROR;
                end else begin
                    state_next = S_WAIT_DONE;
`ifdef MMCM_PS_TIMEOUT_EN
                    to_cnt_next = '0;
`endif
                end
            end
            S_WAIT_DONE: begin
                // Lock loss outranks a coincident PSDONE, so that step is never counted.
                if (!locked) begin
                    lock_err_next = 1'b1;
                    done          = 1'b1;
                    state_next    = S_ERROR;
                end else if (ps_done) begin
                    pos_next  = dir_reg ? pos_reg + ONE : pos_reg - ONE;
                    left_next = left_reg - ONE;
                    if (left_reg == ONE) begin
                        state_next = S_FINISH;
                    end else if (GAP_CYCLES == 0) begin
                        state_next = S_STEP;
                    end else begin
                        state_next   = S_GAP;
                        gap_cnt_next = '0;
                    end
                end
`ifdef MMCM_PS_TIMEOUT_EN
                else if (to_cnt_reg == TO_LIMIT) begin
                    timeout_err_next = 1'b1;
                    done             = 1'b1;
                    state_next       = S_ERROR;
                end else begin
                    to_cnt_next = to_cnt_reg + 16'd1;
                end
`endif
            end
            S_GAP: begin
                if (!locked) begin
                    lock_err_next = 1'b1;
                    done          = 1'b1;
                    state_next    = S_ERROR;
                end else if (gap_cnt_reg == GAP_LAST) begin
                    state_next = S_STEP;
                end else begin
                    gap_cnt_next = gap_cnt_reg + 8'd1;
                end
            end
            S_FINISH: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            S_ERROR: begin
                if (pos_clr) begin
                    pos_next = '0;
                end
                if (err_clr) begin
                    lock_err_next = 1'b0;
`ifdef MMCM_PS_TIMEOUT_EN
                    timeout_err_next = 1'b0;
`endif
                    left_next  = '0;
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge free_run_clk) begin
        if (free_run_rst) begin
            state_reg    <= S_IDLE;
            dir_reg      <= 1'b0;
            left_reg     <= '0;
            pos_reg      <= '0;
            gap_cnt_reg  <= '0;
            lock_err_reg <= 1'b0;
`ifdef MMCM_PS_TIMEOUT_EN
            to_cnt_reg      <= '0;
            timeout_err_reg <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            dir_reg      <= dir_next;
            left_reg     <= left_next;
            pos_reg      <= pos_next;
            gap_cnt_reg  <= gap_cnt_next;
            lock_err_reg <= lock_err_next;
`ifdef MMCM_PS_TIMEOUT_EN
            to_cnt_reg      <= to_cnt_next;
            timeout_err_reg <= timeout_err_next;
`endif
        end
    end

endmodule

// File: tb/tb_mmcm_ps_ctrl.sv
// Bench for mmcm_ps_ctrl: a timing model predicts every output from the command record,
// plus directed scenarios for lock loss, timeout or endless wait, and reset mid-command.
module tb_mmcm_ps_ctrl;
    localparam int POS_W = 16;
    localparam int GAP   = 2;
    localparam int TMO   = 64;

    logic             clk = 1'b0;
    logic             rst, cmd_valid, cmd_dir, pos_clr, err_clr, locked, ps_done;
    logic [POS_W-1:0] cmd_steps;
    logic             cmd_ready, ps_en, ps_incdec, busy, done;
    logic [1:0]       err;
    logic [POS_W-1:0] phase_pos, steps_left;

    mmcm_ps_ctrl #(.POS_W(POS_W), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
        .free_run_clk(clk), .free_run_rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .pos_clr(pos_clr), .err_clr(err_clr),
        .locked(locked), .ps_en(ps_en), .ps_incdec(ps_incdec), .ps_done(ps_done),
        .busy(busy), .done(done), .err(err), .phase_pos(phase_pos), .steps_left(steps_left)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    int en_count = 0;
    int done_count = 0;
    int last_done = -1;

    // Command record the model predicts from; ps_en k of the command lands at m_t+1+k*(lat+1+GAP).
    bit               m_on = 1'b0;
    int               m_t = 0, m_n = 0, m_lat = 1;
    bit               m_dir = 1'b0;
    logic [POS_W-1:0] m_base = '0;
    logic [POS_W-1:0] exp_pos = '0;

    int resp_lat = 0;
    int due = -1;
    int extra = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // MMCM stand-in: PSDONE resp_lat cycles after each PSEN, plus an optional stray pulse.
    initial begin
        forever begin
            @(negedge clk);
            if (ps_en && resp_lat > 0) due = cyc + resp_lat;
        end
    end
    initial begin
        ps_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            ps_done = (cyc == due) || (cyc == extra);
        end
    end

    initial begin
        int p, cnt, dc;
        bit en;
        logic [POS_W-1:0] ep;
        forever begin
            @(negedge clk);
            check("incdec_gated", ps_incdec & ~ps_en, 1'b0);
            if (ps_en) en_count++;
            if (done) done_count++;
            if (m_on && cyc > m_t) begin
                p   = m_lat + 1 + GAP;
                cnt = 0;
                en  = 1'b0;
                for (int k = 0; k < m_n; k++) begin
                    if (cyc == m_t + 1 + k * p) en = 1'b1;
                    if (m_t + 1 + k * p + m_lat + 1 <= cyc) cnt++;
                end
                dc = (m_n == 0) ? m_t + 1 : m_t + (m_n - 1) * p + m_lat + 2;
                ep = m_dir ? m_base + POS_W'(cnt) : m_base - POS_W'(cnt);
                check("m_ps_en", ps_en, en);
                check("m_ps_incdec", ps_incdec, en & m_dir);
                check("m_done", done, cyc == dc);
                check("m_busy", busy, cyc <= dc);
                check("m_cmd_ready", cmd_ready, cyc > dc);
                check("m_phase_pos", phase_pos, ep);
                check("m_steps_left", steps_left, POS_W'(m_n - cnt));
                check("m_err", err, 2'b00);
                if (ps_en && last_done > m_t) check("m_en_spacing", cyc - last_done, GAP + 1);
            end
            if (ps_done) last_done = cyc;
        end
    end

    task automatic run_cmd(input bit dir, input int n, input int lat, input bit clr, input int mid_clr);
        int p, dc;
        p         = lat + 1 + GAP;
        dc        = (n == 0) ? cyc + 1 : cyc + (n - 1) * p + lat + 2;
        resp_lat  = lat;
        cmd_valid = 1'b1;
        cmd_dir   = dir;
        cmd_steps = POS_W'(n);
        pos_clr   = clr;
        m_t       = cyc;
        m_n       = n;
        m_lat     = lat;
        m_dir     = dir;
        m_base    = clr ? '0 : exp_pos;
        m_on      = 1'b1;
        @(negedge clk);
        check("cmd_ready_at_accept", cmd_ready, 1'b1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        pos_clr   = 1'b0;
        if (mid_clr > 0) begin
            goto(m_t + mid_clr);
            pos_clr = 1'b1;
            @(posedge clk);
            #1;
            pos_clr = 1'b0;
        end
        goto(dc + 2);
        exp_pos = dir ? m_base + POS_W'(n) : m_base - POS_W'(n);
    endtask

    initial begin
        int t, e0, d0;
        rst = 1'b1; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_steps = '0;
        pos_clr = 1'b0; err_clr = 1'b0; locked = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        locked = 1'b1;
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_phase_pos", phase_pos, 16'h0000);
        check("rst_steps_left", steps_left, 16'h0000);
        check("rst_err", err, 2'b00);
        check("rst_ps_en", ps_en, 1'b0);
        check("rst_done", done, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("ready_locked_hi", cmd_ready, 1'b1);
        @(posedge clk); #1;
        locked = 1'b0;
        @(negedge clk);
        check("ready_locked_lo", cmd_ready, 1'b0);
        @(posedge clk); #1;
        locked = 1'b1;
        @(negedge clk);
        check("ready_relocked", cmd_ready, 1'b1);
        @(posedge clk); #1;

        // Increment run: 3 steps, PSDONE 12 cycles after PSEN
        e0 = en_count; d0 = done_count;
        run_cmd(1'b1, 3, 12, 1'b0, 0);
        check("inc_en_pulses", en_count - e0, 3);
        check("inc_done_pulses", done_count - d0, 1);
        check("inc_pos", phase_pos, 16'd3);
        check("inc_busy_after", busy, 1'b0);

        // Stray PSDONE while idle must not move the position
        extra = cyc + 2;
        goto(cyc + 6);
        check("stray_done_pos", phase_pos, 16'd3);

        // pos_clr in idle
        m_on = 1'b0;
        pos_clr = 1'b1;
        @(posedge clk); #1;
        pos_clr = 1'b0;
        @(negedge clk);
        check("idle_pos_clr", phase_pos, 16'd0);
        exp_pos = '0;
        @(posedge clk); #1;

        // Decrement wrap, with a pos_clr pulse during the gap that must be ignored
        run_cmd(1'b0, 2, 5, 1'b0, 8);
        check("dec_wrap_pos", phase_pos, 16'hFFFE);

        // Zero-step command
        e0 = en_count; d0 = done_count;
        run_cmd(1'b0, 0, 5, 1'b0, 0);
        check("zero_en_pulses", en_count - e0, 0);
        check("zero_done_pulses", done_count - d0, 1);
        check("zero_pos", phase_pos, 16'hFFFE);

        // pos_clr in the acceptance cycle of a 4-step increment
        run_cmd(1'b1, 4, 2, 1'b1, 0);
        check("clr_accept_pos", phase_pos, 16'd4);

        // Lock loss coinciding with the second PSDONE of a 5-step run
        m_on = 1'b0;
        resp_lat = 4;
        t = cyc;
        cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_steps = 16'd5; pos_clr = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0; pos_clr = 1'b0;
        goto(t + 12);
        locked = 1'b0;
        @(negedge clk);
        check("lock_done_pulse", done, 1'b1);
        @(posedge clk); #1;
        e0 = en_count; d0 = done_count;
        @(negedge clk);
        check("lock_err", err, 2'b01);
        check("lock_pos", phase_pos, 16'd1);
        check("lock_steps_left", steps_left, 16'd4);
        check("lock_busy", busy, 1'b1);
        check("lock_ready", cmd_ready, 1'b0);
        @(posedge clk); #1;
        locked = 1'b1;
        goto(t + 30);
        check("lock_no_more_en", en_count - e0, 0);
        check("lock_single_done", done_count - d0, 0);
        @(negedge clk);
        check("lock_ready_until_clr", cmd_ready, 1'b0);
        @(posedge clk); #1;
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        @(negedge clk);
        check("errclr_err", err, 2'b00);
        check("errclr_steps_left", steps_left, 16'd0);
        check("errclr_busy", busy, 1'b0);
        check("errclr_ready", cmd_ready, 1'b1);
        check("errclr_pos", phase_pos, 16'd1);
        exp_pos = 16'd1;
        @(posedge clk); #1;

`ifdef MMCM_PS_TIMEOUT_EN
        // PSDONE never returned: expiry TMO cycles after entering WAIT_DONE
        resp_lat = 0;
        t = cyc;
        cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_steps = 16'd1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        goto(t + 1 + TMO);
        @(negedge clk);
        check("tmo_done_early", done, 1'b0);
        check("tmo_busy", busy, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        check("tmo_done", done, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        check("tmo_err", err, 2'b10);
        @(posedge clk); #1;
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        @(negedge clk);
        check("tmo_errclr", err, 2'b00);
        check("tmo_ready", cmd_ready, 1'b1);
        @(posedge clk); #1;
        // PSDONE exactly at expiry wins
        t = cyc;
        extra = t + 2 + TMO;
        cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_steps = 16'd1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        goto(t + 2 + TMO);
        @(negedge clk);
        check("race_no_abort", done, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check("race_done", done, 1'b1);
        check("race_err", err, 2'b00);
        check("race_pos", phase_pos, 16'd2);
        @(posedge clk); #1;
`else
        // Without the watchdog WAIT_DONE waits forever
        resp_lat = 0;
        t = cyc;
        cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_steps = 16'd1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        d0 = done_count;
        goto(t + 300);
        check("nowd_no_done", done_count - d0, 0);
        @(negedge clk);
        check("nowd_busy", busy, 1'b1);
        check("nowd_err", err, 2'b00);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("nowd_rst_busy", busy, 1'b0);
        @(posedge clk); #1;
`endif

        // Reset while the third step of a 5-step run is waiting for PSDONE
        resp_lat = 3;
        t = cyc;
        cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_steps = 16'd5;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        goto(t + 14);
        rst = 1'b1;
        e0 = en_count; d0 = done_count;
        @(negedge clk);
        check("midrst_ready", cmd_ready, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_busy", busy, 1'b0);
        check("midrst_pos", phase_pos, 16'd0);
        check("midrst_steps_left", steps_left, 16'd0);
        check("midrst_err", err, 2'b00);
        check("midrst_ps_en", ps_en, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_ready_after", cmd_ready, 1'b1);
        @(posedge clk); #1;
        goto(t + 40);
        check("midrst_no_en", en_count - e0, 0);
        check("midrst_no_done", done_count - d0, 0);
        @(negedge clk);
        check("midrst_pos_hold", phase_pos, 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $finish;
    end
endmodule
